// File: rtl/pipe_mex_wb_gen.sv
// pipe_mex_wb_gen
//   Parametrised MEX->WB pipeline stage. A chain of STAGES rising-edge
//   register slices carries the ALU result, memory data, destination address,
//   mem_read, reg_write and carry flag from the memory/execute stage to the
//   register-file write port. Each slice has a valid bit. Flush clears every
//   slice. Stall holds every slice.
//
//   Optional feature macro: PIPE_MEX_WB_FWD_EN
//     defined   : operand-forwarding compare of every slice against the two EX
//                 read addresses. The youngest matching slice wins.
//     undefined : fwd_sel1/2 and fwd_val1/2 are tied to 0.
//
// Ports
//   clock, reset          : clock and asynchronous active-high reset
//   flush, stall          : invalidate all slices / hold all slices
//   mex_*                 : instruction presented by the MEX stage
//   ex_read_addr1/2       : EX source operand addresses (forwarding compare)
//   mex_ready             : ~stall, purely combinational
//   wb_*                  : fields of the last slice; wb_result is the writeback mux
//   fwd_sel1/2, fwd_val1/2: forwarding hit and forwarded value per operand
module pipe_mex_wb_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int STAGES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              mex_valid,
  input  logic [DATA_W-1:0] mex_write_val,
  input  logic [ADDR_W-1:0] mex_write_addr,
  input  logic [DATA_W-1:0] mex_data_val,
  input  logic              mex_mem_read,
  input  logic              mex_reg_write,
  input  logic              mex_carry_out,
  input  logic [ADDR_W-1:0] ex_read_addr1,
  input  logic [ADDR_W-1:0] ex_read_addr2,
  output logic              mex_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_write_val,
  output logic [ADDR_W-1:0] wb_write_addr,
  output logic [DATA_W-1:0] wb_data_val,
  output logic              wb_mem_read,
  output logic              wb_reg_write,
  output logic              wb_carry_out,
  output logic [DATA_W-1:0] wb_result,
  output logic              fwd_sel1,
  output logic              fwd_sel2,
  output logic [DATA_W-1:0] fwd_val1,
  output logic [DATA_W-1:0] fwd_val2
);

  localparam int LAST = STAGES - 1;

  // Registered slice state
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] mem_read_reg;
  logic [STAGES-1:0] reg_write_reg;
  logic [STAGES-1:0] carry_reg;
  logic [DATA_W-1:0] write_val_reg [STAGES];
  logic [DATA_W-1:0] data_val_reg  [STAGES];
  logic [ADDR_W-1:0] addr_reg      [STAGES];

  // What each slice would capture on an advancing edge
  logic [STAGES-1:0] valid_in;
  logic [STAGES-1:0] mem_read_in;
  logic [STAGES-1:0] reg_write_in;
  logic [STAGES-1:0] carry_in;
  logic [DATA_W-1:0] write_val_in [STAGES];
  logic [DATA_W-1:0] data_val_in  [STAGES];
  logic [ADDR_W-1:0] addr_in      [STAGES];

  // Writeback-mux value of each slice, used by the forwarding compare
  logic [DATA_W-1:0] slice_result [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      if (gi == 0) begin : g_head
        assign valid_in[gi]     = mex_valid;
        assign mem_read_in[gi]  = mex_mem_read;
        assign reg_write_in[gi] = mex_reg_write;
        assign carry_in[gi]     = mex_carry_out;
        assign write_val_in[gi] = mex_write_val;
        assign data_val_in[gi]  = mex_data_val;
        assign addr_in[gi]      = mex_write_addr;
      end else begin : g_tail
        assign valid_in[gi]     = valid_reg[gi-1];
        assign mem_read_in[gi]  = mem_read_reg[gi-1];
        assign reg_write_in[gi] = reg_write_reg[gi-1];
        assign carry_in[gi]     = carry_reg[gi-1];
        assign write_val_in[gi] = write_val_reg[gi-1];
        assign data_val_in[gi]  = data_val_reg[gi-1];
        assign addr_in[gi]      = addr_reg[gi-1];
      end

      // Priority: reset > flush > stall > advance. Flush also zeroes the
      // payload so nothing stale or undefined leaks onto wb_*.
      always_ff @(posedge clock or posedge reset) begin
        if (reset || flush) begin
          valid_reg[gi]     <= 1'b0;
          mem_read_reg[gi]  <= 1'b0;
          reg_write_reg[gi] <= 1'b0;
          carry_reg[gi]     <= 1'b0;
          write_val_reg[gi] <= '0;
          data_val_reg[gi]  <= '0;
          addr_reg[gi]      <= '0;
        end else if (!stall) begin
          valid_reg[gi]     <= valid_in[gi];
          mem_read_reg[gi]  <= mem_read_in[gi];
          reg_write_reg[gi] <= reg_write_in[gi];
          carry_reg[gi]     <= carry_in[gi];
          write_val_reg[gi] <= write_val_in[gi];
          data_val_reg[gi]  <= data_val_in[gi];
          addr_reg[gi]      <= addr_in[gi];
        end
      end

      assign slice_result[gi] = mem_read_reg[gi] ? data_val_reg[gi] : write_val_reg[gi];
    end
  endgenerate

  assign mex_ready     = ~stall;
  assign wb_valid      = valid_reg[LAST];
  assign wb_write_val  = write_val_reg[LAST];
  assign wb_write_addr = addr_reg[LAST];
  assign wb_data_val   = data_val_reg[LAST];
  assign wb_mem_read   = mem_read_reg[LAST];
  assign wb_reg_write  = valid_reg[LAST] & reg_write_reg[LAST];
  assign wb_carry_out  = carry_reg[LAST];
  assign wb_result     = slice_result[LAST];

`ifdef PIPE_MEX_WB_FWD_EN
  logic [STAGES-1:0] hit1;
  logic [STAGES-1:0] hit2;

  // Register 0 is hard-wired zero, so it is never a forwarding source.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_fwd
      assign hit1[gi] = valid_reg[gi] & reg_write_reg[gi] & (addr_reg[gi] != '0)
                        & (addr_reg[gi] == ex_read_addr1);
      assign hit2[gi] = valid_reg[gi] & reg_write_reg[gi] & (addr_reg[gi] != '0)
                        & (addr_reg[gi] == ex_read_addr2);
    end
  endgenerate

  // Scan oldest to youngest so the youngest hit is assigned last and wins.
  always_comb begin
    fwd_sel1 = 1'b0;
    fwd_sel2 = 1'b0;
    fwd_val1 = '0;
    fwd_val2 = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        fwd_sel1 = 1'b1;
        fwd_val1 = slice_result[i];
      end
      if (hit2[i]) begin
        fwd_sel2 = 1'b1;
        fwd_val2 = slice_result[i];
      end
    end
  end
`else
  assign fwd_sel1 = 1'b0;
  assign fwd_sel2 = 1'b0;
  assign fwd_val1 = '0;
  assign fwd_val2 = '0;
  // Read addresses only feed the forwarding compare.
  logic unused_read_addr;
  assign unused_read_addr = ^{ex_read_addr1, ex_read_addr2};
`endif

endmodule

// File: doc/pipe_mex_wb_gen.md
Name: pipe_mex_wb_gen

Overview:
- Parametrised MEX→WB pipeline stage.
- Carries ALU result, memory data, destination address, mem_read, reg_write and carry flag from the combined memory/execute stage to writeback.
- Adds over the previous stage:
  - configurable data/address width and register depth;
  - per-entry valid bit, stall and flush handling;
  - writeback result mux;
  - optional operand-forwarding compare against the two EX read addresses.
- Sits between the MEX stage and the register-file write port.

Parameters:
- DATA_W, 8: width of write_val, data_val and result.
- ADDR_W, 3: register address width.
- STAGES, 1: number of register slices between MEX and WB. Legal range 1–4. Latency equals STAGES cycles.

Ports:
- clock  in  1: single clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high; clears all state.
- flush  in  1: invalidates every slice at the next edge.
- stall  in  1: WB cannot accept; all slices hold.
- mex_valid  in  1: MEX presents a live instruction.
- mex_write_val  in  DATA_W: ALU result.
- mex_write_addr  in  ADDR_W: destination register.
- mex_data_val  in  DATA_W: memory read data.
- mex_mem_read  in  1: result comes from memory.
- mex_reg_write  in  1: instruction writes the register file.
- mex_carry_out  in  1: ALU carry.
- ex_read_addr1  in  ADDR_W: EX source operand 1 address.
- ex_read_addr2  in  ADDR_W: EX source operand 2 address.
- mex_ready  out  1: equals ~stall (combinational).
- wb_valid  out  1: last slice holds a live instruction.
- wb_write_val  out  DATA_W
- wb_write_addr  out  ADDR_W
- wb_data_val  out  DATA_W
- wb_mem_read  out  1
- wb_reg_write  out  1: wb_valid & registered reg_write.
- wb_carry_out  out  1
- wb_result  out  DATA_W: wb_mem_read ? wb_data_val : wb_write_val.
- fwd_sel1  out  1: forward to operand 1.
- fwd_sel2  out  1: forward to operand 2.
- fwd_val1  out  DATA_W: forwarded value for operand 1.
- fwd_val2  out  DATA_W: forwarded value for operand 2.

Behaviour:
- Reset (asynchronous, active-high): every slice valid=0 and payload=0. All registered outputs read 0. fwd_sel1/2=0 and fwd_val1/2=0 during and after reset until new data is captured.
- Single rising-edge register per slice. There is no negedge half-stage: the old split-edge scheme is dropped.
- Slice 0 captures the MEX inputs. Slice k captures slice k-1. The last slice drives the wb_* outputs.
- Edge-event priority: reset > flush > stall > advance.
  - flush=1: all valid bits ← 0. Payload ← 0 (no X propagation). This applies even with stall=1.
  - stall=1, flush=0: every slice holds value and valid. MEX inputs are ignored.
  - Otherwise: shift by one. Slice 0 valid ← mex_valid.
- Latency: an instruction with mex_valid=1 at edge N (no stall) appears on wb_valid after edge N+STAGES-1. STAGES=1 gives a one-cycle register.
- An invalid slice never asserts wb_reg_write and is never a forwarding source.
- wb_result is combinational from the last slice's registered fields. It is 0 while in reset.
- Address 0 is the hard-wired zero register. A destination of 0 is carried through the pipe but never matches for forwarding.
- mex_ready is purely combinational and has no registered path.

Optional Feature:
- Macro: PIPE_MEX_WB_FWD_EN.
- Defined: each slice is a forwarding source when valid & reg_write & addr≠0 & addr==ex_read_addrN.
  - Youngest slice (slice 0) wins over older slices.
  - fwd_valN = that slice's result (mem_read ? data_val : write_val).
  - Compare is combinational, from registered slice state and live ex_read_addr1/2.
- Undefined: fwd_sel1, fwd_sel2, fwd_val1 and fwd_val2 are tied to 0. No compare logic is synthesised.

Test Plan:
- Reset / latency: DATA_W=8, STAGES=1. Pulse reset mid-cycle → all outputs 0 immediately, without waiting for an edge. Release; drive mex_valid=1, write_val=0x5A, addr=3, reg_write=1 → one edge later wb_valid=1, wb_result=0x5A, wb_write_addr=3.
- Depth and mux: STAGES=3. Issue three back-to-back instructions:
  - write_val=0x11, mem_read=0
  - data_val=0x22, mem_read=1
  - write_val=0x33, mem_read=0

  Expected: wb_result reads 0x11, 0x22, 0x33 on edges 3, 4 and 5.
- Stall / flush priority: STAGES=2, pipe full. stall=1 for 2 cycles → wb_* stable and new MEX input ignored. Then stall=1 with flush=1 → wb_valid=0, wb_reg_write=0 on the next edge.
- Forwarding (FWD_EN):
  - Slice 0 holds addr 2 = 0x44; slice 1 holds addr 2 = 0x99. ex_read_addr1=2 → fwd_sel1=1, fwd_val1=0x44.
  - ex_read_addr2=5 → fwd_sel2=0.
- Forwarding exclusions (FWD_EN): valid slice with addr 0 and reg_write=1; also a slice with valid=0 and matching addr → fwd_sel1=0 in both cases.
- Without FWD_EN: repeat the forwarding case → fwd_sel1=0, fwd_val1=0.
